cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Sequencer and write-port arbiter for the cache data RAM. Accepts a line-miss request, writes back the dirty victim line over the write bus, fetches the new line over the read bus, and writes the returned words into the data RAM one word per beat. Between refills it grants the single RAM write port to CPU store hits. Sits between the cache lookup pipeline, the data RAM and the bus interface.

## Interface
Parameters:
- LOG_H, 8, log2 of set count
- LOG_N, 1, log2 of ways
- LOG_W, 2, log2 of words per line (W = 2**LOG_W)
- TAG_W, 20, tag width; TAG_W+LOG_H+LOG_W+2 = 32

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- miss_req  in  1  refill request
- miss_ready  out  1  request accepted this cycle
- miss_index  in  LOG_H  set
- miss_way  in  LOG_N  victim way
- miss_offset  in  LOG_W  missing word
- miss_tag  in  TAG_W  new tag
- victim_tag  in  TAG_W  victim tag
- victim_dirty  in  1  victim needs writeback
- st_valid / st_ready  in / out  1  CPU store handshake
- st_index, st_way, st_offset, st_data  in  LOG_H, LOG_N, LOG_W, 32  store target/data
- ram_we  out  1  data RAM write enable
- ram_index, ram_way, ram_offset  out  LOG_H, LOG_N, LOG_W  data RAM address
- ram_din  out  32  data RAM write data
- ram_line  in  W*32  data RAM current line (combinational read of ram_index/ram_way)
- wr_req / wr_rdy  out / in  1  writeback handshake
- wr_addr  out  32  {victim_tag, index, LOG_W+2 zeros}
- wr_data  out  W*32  victim line
- rd_req / rd_rdy  out / in  1  line-read handshake
- rd_addr  out  32  {miss_tag, index, LOG_W+2 zeros}
- rd_ret_valid  in  1  returned word valid
- rd_ret_data  in  32  returned word, offset 0 first
- refill_done  out  1  one-cycle pulse, line complete
- fwd_valid / fwd_data  out  1 / 32  critical-word forward (REFILL_FWD_EN only)

## Operation
- States: IDLE, WB_CAP, WB_REQ, RD_REQ, REFILL, DONE.
- IDLE: st_ready=1. st_valid → ram_we=1 with store fields, same cycle. miss_req with st_valid low → miss_ready=1, latch miss fields; next state WB_CAP if victim_dirty else RD_REQ. Simultaneous store and miss: store wins, miss_ready=0, miss retried next cycle.
- WB_CAP: ram_index/ram_way = latched set/way; capture ram_line into wr_data register → WB_REQ.
- WB_REQ: wr_req=1 held until wr_rdy sampled high → RD_REQ. wr_addr/wr_data stable while wr_req high.
- RD_REQ: rd_req=1 held until rd_rdy → REFILL, beat counter cleared.
- REFILL: each rd_ret_valid → ram_we=1, ram_offset=counter, ram_din=rd_ret_data, counter+1. Beat W-1 → DONE. Counter wraps on LOG_W bits; no further writes.
- DONE: refill_done=1 one cycle → IDLE.
- st_ready=0 in every state except IDLE; ram_we only from the store grant or a REFILL beat.
- Reset: all states/registers cleared immediately; every output 0 except st_ready=0 while reset asserted, 1 on first IDLE cycle after release. Partial refill abandoned; the line's valid bit is owned by the caller and is not set without refill_done.

## Timing
- Clean miss: miss accept at cycle 0, rd_req from cycle 1; refill_done one cycle after last beat.
- Dirty miss adds WB_CAP (1 cycle) plus the wr handshake.
- Store write latency 0 (combinational grant); data RAM write occurs on the next clk edge.
- Back-to-back beats: one word per cycle; gaps allowed.

## Configuration
- REFILL_FWD_EN defined: in REFILL, when counter equals latched miss_offset and rd_ret_valid, fwd_valid=1 and fwd_data=rd_ret_data for that cycle.
- Undefined: fwd_valid/fwd_data tied 0; the CPU rereads after refill_done.

## Test plan
- Clean miss index 5 way 1, beats 0xA0..0xA3 → four ram_we, offsets 0..3 with those data; refill_done one cycle after beat 3; wr_req never high.
- Dirty miss, RAM line {4,3,2,1}, victim_tag 0x12345, index 0x7 → wr_data = line, wr_addr 0x123450 70, wr_req held through 3 wr_rdy-low cycles, then rd_req.
- Store and miss same IDLE cycle → store written, miss_ready=0; miss accepted next cycle.
- Store during REFILL → st_ready=0, no store write until after refill_done.
- resetn low mid-REFILL after 2 beats → outputs 0 at once; after release, IDLE, st_ready=1, no refill_done.
- REFILL_FWD_EN, miss_offset 2, beats with one-cycle gaps → fwd_valid exactly on beat 2, fwd_data = beat 2 data.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Refill sequencer and write-port arbiter for the cache data RAM.
//
// On a line miss it optionally writes back the dirty victim line, fetches the
// new line over the read bus and writes the returned words into the data RAM
// one word per beat.  While no refill is in flight (IDLE) the single RAM write
// port is granted to CPU store hits, combinationally, in the same cycle.
//
// Optional feature (macro REFILL_FWD_EN):
//   defined   : the critical (missing) word is forwarded on fwd_valid/fwd_data
//               in the cycle it returns from the bus.
//   undefined : fwd_valid/fwd_data are tied to 0.
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   miss_req / miss_ready           line-miss request handshake
//   miss_index/way/offset/tag       set, victim way, missing word, new tag
//   victim_tag, victim_dirty        victim line tag and writeback flag
//   st_valid / st_ready             CPU store-hit handshake
//   st_index/way/offset/data        store target and data
//   ram_we, ram_index/way/offset    data RAM write port / address
//   ram_din                         data RAM write data
//   ram_line                        data RAM line at ram_index/ram_way
//   wr_req / wr_rdy, wr_addr/data   victim writeback handshake, address, line
//   rd_req / rd_rdy, rd_addr        line-read handshake and address
//   rd_ret_valid, rd_ret_data       returned words, offset 0 first
//   refill_done                     one-cycle pulse when the line is complete
//   fwd_valid, fwd_data             critical-word forward
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int LOG_H = 8,
    parameter int LOG_N = 1,
    parameter int LOG_W = 2,
    parameter int TAG_W = 20
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        miss_req,
    output logic                        miss_ready,
    input  logic [LOG_H-1:0]            miss_index,
    input  logic [LOG_N-1:0]            miss_way,
    input  logic [LOG_W-1:0]            miss_offset,
    input  logic [TAG_W-1:0]            miss_tag,
    input  logic [TAG_W-1:0]            victim_tag,
    input  logic                        victim_dirty,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [LOG_H-1:0]            st_index,
    input  logic [LOG_N-1:0]            st_way,
    input  logic [LOG_W-1:0]            st_offset,
    input  logic [31:0]                 st_data,
    output logic                        ram_we,
    output logic [LOG_H-1:0]            ram_index,
    output logic [LOG_N-1:0]            ram_way,
    output logic [LOG_W-1:0]            ram_offset,
    output logic [31:0]                 ram_din,
    input  logic [(2**LOG_W)*32-1:0]    ram_line,
    output logic                        wr_req,
    input  logic                        wr_rdy,
    output logic [31:0]                 wr_addr,
    output logic [(2**LOG_W)*32-1:0]    wr_data,
    output logic                        rd_req,
    input  logic                        rd_rdy,
    output logic [31:0]                 rd_addr,
    input  logic                        rd_ret_valid,
    input  logic [31:0]                 rd_ret_data,
    output logic                        refill_done,
    output logic                        fwd_valid,
    output logic [31:0]                 fwd_data
);

    localparam int W = 2**LOG_W;

    typedef enum logic [2:0] {
        IDLE,
        WB_CAP,
        WB_REQ,
        RD_REQ,
        REFILL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_H-1:0]    index_q, index_d;
    logic [LOG_N-1:0]    way_q, way_d;
    logic [LOG_W-1:0]    off_q, off_d;
    logic [TAG_W-1:0]    mtag_q, mtag_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [W*32-1:0]     wdata_q, wdata_d;
    logic [LOG_W-1:0]    cnt_q, cnt_d;
    logic                wr_req_q, rd_req_q, done_q;

    logic idle;
    logic store_go;
    logic miss_go;
    logic beat;

    // The store grant is gated by resetn so that nothing is granted while the
    // reset is held, even though the state register already reads IDLE.
    assign idle     = resetn && (state_q == IDLE);
    assign store_go = idle && st_valid;
    // A store in the same cycle wins; the miss simply retries next cycle.
    assign miss_go  = idle && miss_req && !st_valid;
    assign beat     = (state_q == REFILL) && rd_ret_valid;

    assign st_ready    = idle;
    assign miss_ready  = miss_go;
    assign wr_req      = wr_req_q;
    assign rd_req      = rd_req_q;
    assign refill_done = done_q;
    assign wr_data     = wdata_q;
    assign wr_addr     = {vtag_q, index_q, {(LOG_W+2){1'b0}}};
    assign rd_addr     = {mtag_q, index_q, {(LOG_W+2){1'b0}}};

    // Data RAM port: store grant in IDLE, latched set/way while capturing the
    // victim or refilling; the write itself happens only on a store or a beat.
    always_comb begin
        ram_we     = store_go || beat;
        ram_index  = '0;
        ram_way    = '0;
        ram_offset = '0;
        ram_din    = '0;
        if (store_go) begin
            ram_index  = st_index;
            ram_way    = st_way;
            ram_offset = st_offset;
            ram_din    = st_data;
        end else if (state_q == WB_CAP || state_q == REFILL) begin
            ram_index = index_q;
            ram_way   = way_q;
            if (beat) begin
                ram_offset = cnt_q;
                ram_din    = rd_ret_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        way_d   = way_q;
        off_d   = off_q;
        mtag_d  = mtag_q;
        vtag_d  = vtag_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (miss_go) begin
                    index_d = miss_index;
                    way_d   = miss_way;
                    off_d   = miss_offset;
                    mtag_d  = miss_tag;
                    vtag_d  = victim_tag;
                    state_d = victim_dirty ? WB_CAP : RD_REQ;
                end
            end
            WB_CAP: begin
                // ram_line reflects the latched set/way driven this cycle.
                wdata_d = ram_line;
                state_d = WB_REQ;
            end
            WB_REQ: begin
                if (wr_rdy) state_d = RD_REQ;
            end
            RD_REQ: begin
                if (rd_rdy) begin
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (rd_ret_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            index_q  <= '0;
            way_q    <= '0;
            off_q    <= '0;
            mtag_q   <= '0;
            vtag_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            way_q    <= way_d;
            off_q    <= off_d;
            mtag_q   <= mtag_d;
            vtag_q   <= vtag_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            wr_req_q <= (state_d == WB_REQ);
            rd_req_q <= (state_d == RD_REQ);
            done_q   <= (state_d == DONE);
        end
    end

`ifdef REFILL_FWD_EN
    // Forward the critical word in the cycle it arrives.
    assign fwd_valid = beat && (cnt_q == off_q);
    assign fwd_data  = fwd_valid ? rd_ret_data : 32'd0;
`else
    logic unused_off;
    assign unused_off = ^off_q;
    assign fwd_valid  = 1'b0;
    assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic         clk;
    logic         resetn;
    logic         miss_req, miss_ready;
    logic [7:0]   miss_index;
    logic [0:0]   miss_way;
    logic [1:0]   miss_offset;
    logic [19:0]  miss_tag, victim_tag;
    logic         victim_dirty;
    logic         st_valid, st_ready;
    logic [7:0]   st_index;
    logic [0:0]   st_way;
    logic [1:0]   st_offset;
    logic [31:0]  st_data;
    logic         ram_we;
    logic [7:0]   ram_index;
    logic [0:0]   ram_way;
    logic [1:0]   ram_offset;
    logic [31:0]  ram_din;
    logic [127:0] ram_line;
    logic         wr_req, wr_rdy;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic         rd_req, rd_rdy;
    logic [31:0]  rd_addr;
    logic         rd_ret_valid;
    logic [31:0]  rd_ret_data;
    logic         refill_done;
    logic         fwd_valid;
    logic [31:0]  fwd_data;

`ifdef REFILL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    cache_refill_ctrl dut (
        .clk(clk), .resetn(resetn),
        .miss_req(miss_req), .miss_ready(miss_ready),
        .miss_index(miss_index), .miss_way(miss_way), .miss_offset(miss_offset),
        .miss_tag(miss_tag), .victim_tag(victim_tag), .victim_dirty(victim_dirty),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_index(st_index), .st_way(st_way), .st_offset(st_offset), .st_data(st_data),
        .ram_we(ram_we), .ram_index(ram_index), .ram_way(ram_way),
        .ram_offset(ram_offset), .ram_din(ram_din), .ram_line(ram_line),
        .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rd_ret_valid(rd_ret_valid), .rd_ret_data(rd_ret_data),
        .refill_done(refill_done), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM model written by the DUT, and the reference contents the
    // bench expects from the sequence of stores and refills it issued.
    logic [31:0] mem     [0:255][0:1][0:3];
    logic [31:0] ref_mem [0:255][0:1][0:3];
    logic        clr;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++)
                for (int j = 0; j < 2; j++)
                    for (int k = 0; k < 4; k++)
                        mem[i][j][k] <= 32'd0;
        end else if (ram_we) begin
            mem[ram_index][ram_way][ram_offset] <= ram_din;
        end
    end

    always_comb begin
        ram_line = '0;
        for (int i = 0; i < 4; i++) ram_line[i*32 +: 32] = mem[ram_index][ram_way][i];
    end

    function automatic logic [127:0] ref_line(input logic [7:0] idx, input logic w);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = ref_mem[idx][w][i];
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [7:0] idx, input logic w);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem[idx][w][i];
        return l;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Store through the IDLE grant; optionally with a competing miss that must lose.
    task automatic do_store(input logic [7:0] idx, input logic w, input logic [1:0] off,
                            input logic [31:0] d, input logic with_miss);
        st_valid = 1'b1; st_index = idx; st_way = w; st_offset = off; st_data = d;
        miss_req = with_miss;
        @(negedge clk);
        chk("st_ready", st_ready, 1'b1);
        chk("st_we", ram_we, 1'b1);
        chk("st_addr", {ram_index, ram_way, ram_offset}, {idx, w, off});
        chk("st_din", ram_din, d);
        chk("st_miss_ready", miss_ready, 1'b0);
        step();
        st_valid = 1'b0;
        miss_req = 1'b0;
        ref_mem[idx][w][off] = d;
    endtask

    // One complete miss. gapmode: 0 back-to-back, 1 one idle cycle between
    // beats, 2 random 0..2 idle cycles. stn holds a store request during the refill.
    task automatic do_miss(input logic [7:0] idx, input logic w, input logic [1:0] off,
                           input logic [19:0] tag, input logic [19:0] vtag, input logic dirty,
                           input int wwait, input int rwait, input int gapmode,
                           input logic [127:0] beats, input logic stn);
        logic [127:0] exp_line;
        int gaps;
        exp_line = ref_line(idx, w);
        miss_req = 1'b1; miss_index = idx; miss_way = w; miss_offset = off;
        miss_tag = tag; victim_tag = vtag; victim_dirty = dirty;
        @(negedge clk);
        chk("miss_ready", miss_ready, 1'b1);
        chk("miss_wr_req", wr_req, 1'b0);
        step();
        // Scramble the request inputs: the controller must use latched values.
        miss_req = 1'b0; miss_index = ~idx; miss_way = ~w; miss_offset = ~off;
        miss_tag = ~tag; victim_tag = ~vtag;
        st_valid = stn;
        if (dirty) begin
            @(negedge clk);
            chk("wbcap_addr", {ram_index, ram_way}, {idx, w});
            chk("wbcap_req", {wr_req, rd_req, ram_we, st_ready}, 4'b0000);
            step();
            for (int k = 0; k <= wwait; k++) begin
                wr_rdy = (k == wwait);
                @(negedge clk);
                chk("wb_wr_req", wr_req, 1'b1);
                chk("wb_wr_addr", wr_addr, {vtag, idx, 4'b0000});
                chk("wb_wr_data", wr_data, exp_line);
                chk("wb_other", {rd_req, ram_we, st_ready}, 3'b000);
                step();
            end
            wr_rdy = 1'b0;
        end
        for (int k = 0; k <= rwait; k++) begin
            rd_rdy = (k == rwait);
            @(negedge clk);
            chk("rd_req", rd_req, 1'b1);
            chk("rd_addr", rd_addr, {tag, idx, 4'b0000});
            chk("rd_other", {wr_req, ram_we, st_ready}, 3'b000);
            step();
        end
        rd_rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            gaps = (gapmode == 0) ? 0 : (gapmode == 1) ? ((n > 0) ? 1 : 0) : $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                rd_ret_valid = 1'b0;
                @(negedge clk);
                chk("gap_idle", {ram_we, rd_req, refill_done, fwd_valid, st_ready}, 5'b0);
                step();
            end
            rd_ret_valid = 1'b1;
            rd_ret_data  = beats[n*32 +: 32];
            @(negedge clk);
            chk("beat_we", ram_we, 1'b1);
            chk("beat_addr", {ram_index, ram_way, ram_offset}, {idx, w, n[1:0]});
            chk("beat_din", ram_din, beats[n*32 +: 32]);
            chk("beat_ctl", {refill_done, wr_req, rd_req, st_ready}, 4'b0000);
            chk("beat_fwd_v", fwd_valid, FWD && (n == int'(off)));
            chk("beat_fwd_d", fwd_data, (FWD && (n == int'(off))) ? beats[n*32 +: 32] : 32'd0);
            ref_mem[idx][w][n] = beats[n*32 +: 32];
            step();
        end
        rd_ret_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", refill_done, 1'b1);
        chk("done_other", {ram_we, st_ready, rd_req, wr_req}, 4'b0000);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("after_done", {refill_done, st_ready}, 2'b01);
        chk("line", mem_line(idx, w), ref_line(idx, w));
        step();
    endtask

    typedef struct {
        logic        sv;
        logic        mr;
        logic [7:0]  idx;
        logic        way;
        logic [1:0]  off;
        logic [31:0] d;
        logic        e_we;
        logic        e_mr;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 8'h21, 1'b1, 2'd3, 32'h1111_2222, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'h05, 1'b0, 2'd1, 32'h0,        1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 8'hF0, 1'b0, 2'd2, 32'h3333_4444, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b0, 8'h7E, 1'b1, 2'd0, 32'h5555_6666, 1'b1, 1'b0};

        resetn = 1'b0; clr = 1'b1;
        miss_req = 0; miss_index = 0; miss_way = 0; miss_offset = 0; miss_tag = 0;
        victim_tag = 0; victim_dirty = 0; st_valid = 0; st_index = 0; st_way = 0;
        st_offset = 0; st_data = 0; wr_rdy = 0; rd_rdy = 0; rd_ret_valid = 0; rd_ret_data = 0;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 4; k++) ref_mem[i][j][k] = 32'd0;
        step();
        clr = 1'b0;

        // Reset: every output low even with live requests.
        st_valid = 1'b1; st_data = 32'hFFFF_FFFF; miss_req = 1'b1; rd_ret_valid = 1'b1;
        rd_ret_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rst_ctl", {st_ready, miss_ready, ram_we, wr_req, rd_req, refill_done, fwd_valid}, 7'b0);
        chk("rst_data", {ram_index, ram_way, ram_offset, ram_din, fwd_data}, '0);
        chk("rst_addr", {wr_addr, rd_addr}, 64'd0);
        chk("rst_wdata", wr_data, 128'd0);
        st_valid = 1'b0; miss_req = 1'b0; rd_ret_valid = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_st_ready", st_ready, 1'b1);
        chk("post_rst_idle", {ram_we, rd_req, wr_req, refill_done}, 4'b0);
        step();

        // IDLE arbitration table (requests withdrawn before the edge).
        for (int i = 0; i < 5; i++) begin
            st_valid = vt[i].sv; miss_req = vt[i].mr; victim_dirty = vt[i].idx[0];
            st_index = vt[i].idx; st_way = vt[i].way; st_offset = vt[i].off; st_data = vt[i].d;
            miss_index = ~vt[i].idx;
            @(negedge clk);
            chk("tbl_st_ready", st_ready, 1'b1);
            chk("tbl_we", ram_we, vt[i].e_we);
            chk("tbl_miss_ready", miss_ready, vt[i].e_mr);
            if (vt[i].e_we) begin
                chk("tbl_addr", {ram_index, ram_way, ram_offset}, {vt[i].idx, vt[i].way, vt[i].off});
                chk("tbl_din", ram_din, vt[i].d);
            end
            #1;
            st_valid = 1'b0; miss_req = 1'b0;
            step();
        end

        // Clean miss, back-to-back beats A0..A3.
        do_miss(8'd5, 1'b1, 2'd0, 20'h0F00D, 20'h0BEEF, 1'b0, 0, 0, 0,
                128'h000000A3_000000A2_000000A1_000000A0, 1'b0);

        // Dirty miss: victim line {4,3,2,1}, wr_rdy low for 3 cycles.
        for (int i = 0; i < 4; i++) do_store(8'd7, 1'b0, i[1:0], 32'(i + 1), 1'b0);
        chk("dirty_line_setup", ref_line(8'd7, 1'b0), 128'h00000004_00000003_00000002_00000001);
        do_miss(8'd7, 1'b0, 2'd1, 20'hABCDE, 20'h12345, 1'b1, 3, 1, 0,
                128'h000000B3_000000B2_000000B1_000000B0, 1'b0);

        // Store and miss collide: store wins, miss retried; store held during refill.
        do_store(8'd3, 1'b1, 2'd2, 32'hCAFE_0001, 1'b1);
        st_index = 8'd6; st_way = 1'b1; st_offset = 2'd0; st_data = 32'hDEAD_0006;
        do_miss(8'd4, 1'b0, 2'd3, 20'h00444, 20'h00000, 1'b0, 0, 0, 2,
                128'h0000C003_0000C002_0000C001_0000C000, 1'b1);
        chk("held_store_not_written", mem[6][1][0], 32'd0);
        do_store(8'd6, 1'b1, 2'd0, 32'hDEAD_0006, 1'b0);

        // Reset after two beats of a refill.
        miss_req = 1'b1; miss_index = 8'd9; miss_way = 1'b0; miss_offset = 2'd0;
        miss_tag = 20'h99999; victim_dirty = 1'b0;
        @(negedge clk);
        chk("r_miss_ready", miss_ready, 1'b1);
        step();
        miss_req = 1'b0; rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0; rd_ret_valid = 1'b1; rd_ret_data = 32'h11;
        step();
        rd_ret_data = 32'h22;
        step();
        ref_mem[9][0][0] = 32'h11; ref_mem[9][0][1] = 32'h22;
        rd_ret_data = 32'h33; st_valid = 1'b1; miss_req = 1'b1; resetn = 1'b0;
        #1;
        chk("rmid_ctl", {st_ready, miss_ready, ram_we, wr_req, rd_req, refill_done, fwd_valid}, 7'b0);
        chk("rmid_data", {ram_din, rd_addr}, 64'd0);
        step();
        st_valid = 1'b0; miss_req = 1'b0; resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rrel_st_ready", st_ready, 1'b1);
            chk("rrel_quiet", {ram_we, refill_done, rd_req, wr_req}, 4'b0);
            step();
        end
        rd_ret_valid = 1'b0;
        chk("rrel_line", mem_line(8'd9, 1'b0), ref_line(8'd9, 1'b0));

        // Critical-word forwarding with one-cycle gaps.
        do_miss(8'd10, 1'b1, 2'd2, 20'h0AAAA, 20'h0, 1'b0, 0, 0, 1,
                128'hF0000003_F0000002_F0000001_F0000000, 1'b0);

        // Randomized traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_store(8'($urandom_range(0, 15)), 1'($urandom), 2'($urandom),
                         $urandom, 1'($urandom));
            end else begin
                st_index = 8'($urandom_range(0, 15)); st_way = 1'($urandom);
                st_offset = 2'($urandom); st_data = $urandom;
                do_miss(8'($urandom_range(0, 15)), 1'($urandom), 2'($urandom),
                        20'($urandom), 20'($urandom), 1'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 3), 2,
                        {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            end
        end

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("final_line_%0d_%0d", i, j), mem_line(8'(i), 1'(j)), ref_line(8'(i), 1'(j)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
